// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings for the dmem arbiter: FSM states, read-return select, byte enables.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dmem_arbiter_pkg;

    // Arbiter FSM: normal CPU-priority operation or the single forced loader cycle
    typedef enum logic {
        ARB_NORMAL  = 1'b0,
        ARB_FORCE_B = 1'b1
    } arb_state_t;

    // Owner of the read data coming back from the banks next cycle
    typedef enum logic [1:0] {
        RSEL_NONE = 2'd0,
        RSEL_A    = 2'd1,
        RSEL_B    = 2'd2
    } rsel_t;

    // All byte lanes disabled; an access with this enable pattern is a read
    localparam logic [3:0] WE_NONE = 4'b0000;

    function automatic logic is_read(input logic [3:0] we);
        return (we == WE_NONE);
    endfunction

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Counts consecutive loader denials and flags when the next cycle must be a forced loader grant.
// Latency: force_next is combinational from the current count and deny.
// Backpressure: none; clear wins over deny, and force_next restarts the count.
module dmem_arb_starve_ctr #(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic deny,
    input  logic clear,
    output logic force_next
);
    import dmem_arbiter_pkg::*;

    localparam logic [7:0] LIMIT_M1 = 8'(STARVE_LIMIT - 1);

    logic [7:0] starve_cnt;

    // The denial that reaches the limit schedules the forced cycle
    assign force_next = deny && (starve_cnt == LIMIT_M1);

    // Consecutive-denial counter; any grant to B or B going idle restarts it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= 8'd0;
        end else if (force_next || clear) begin
            starve_cnt <= 8'd0;
        end else if (deny) begin
            starve_cnt <= starve_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the dmem banks between the CPU (port A, priority) and a loader (port B, req/gnt), routes read data back.
// Latency: grant and mem_* are combinational (zero added latency for A); read data returns one cycle after grant.
// Backpressure: B holds b_req until b_gnt; after STARVE_LIMIT denials the CPU is stalled one cycle (cpu_stall). Optional DMEM_ARB_STATS_EN adds counters.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic [3:0]        a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [31:0]       a_wdata,
    output logic [31:0]       a_rdata,
    output logic              a_rvalid,
    output logic              cpu_stall,
    input  logic              b_req,
    input  logic [3:0]        b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [31:0]       b_wdata,
    output logic              b_gnt,
    output logic [31:0]       b_rdata,
    output logic              b_rvalid,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [31:0]       conflict_cnt,
    output logic [15:0]       force_cnt
`endif
);

    arb_state_t state;
    rsel_t      rsel;
    rsel_t      rsel_next;
    logic       gnt_a;
    logic       gnt_b;
    logic       deny;
    logic       clear;
    logic       force_next;

    // A owns the banks in normal state; B takes any cycle A leaves free; nothing is granted during reset
    always_comb begin
        gnt_a     = !rst && (state == ARB_NORMAL) && a_req;
        gnt_b     = !rst && b_req && !gnt_a;
        mem_we    = WE_NONE;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt_a) begin
            mem_we    = a_we;
            mem_addr  = a_addr;
            mem_wdata = a_wdata;
        end else if (gnt_b) begin
            mem_we    = b_we;
            mem_addr  = b_addr;
            mem_wdata = b_wdata;
        end
    end

    assign b_gnt     = gnt_b;
    assign cpu_stall = (state == ARB_FORCE_B);

    // A denial is only counted in normal state, where A beat a waiting B
    assign deny  = (state == ARB_NORMAL) && a_req && b_req;
    assign clear = gnt_b || !b_req;

    dmem_arb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk        (clk),
        .rst        (rst),
        .deny       (deny),
        .clear      (clear),
        .force_next (force_next)
    );

    // Forced cycle lasts exactly one cycle, then back to CPU priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB_NORMAL;
        end else begin
            state <= force_next ? ARB_FORCE_B : ARB_NORMAL;
        end
    end

    // Remember who owns the read data the banks return next cycle
    always_comb begin
        rsel_next = RSEL_NONE;
        if (gnt_a && is_read(a_we)) begin
            rsel_next = RSEL_A;
        end else if (gnt_b && is_read(b_we)) begin
            rsel_next = RSEL_B;
        end
    end

    // Reset drops any in-flight return so no stale rvalid follows it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsel <= RSEL_NONE;
        end else begin
            rsel <= rsel_next;
        end
    end

    assign a_rvalid = (rsel == RSEL_A);
    assign b_rvalid = (rsel == RSEL_B);
    assign a_rdata  = a_rvalid ? mem_rdata : 32'd0;
    assign b_rdata  = b_rvalid ? mem_rdata : 32'd0;

`ifdef DMEM_ARB_STATS_EN
    // Saturating counts of denial cycles and forced-cycle entries
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt <= 32'd0;
            force_cnt    <= 16'd0;
        end else begin
            if (deny && (conflict_cnt != 32'hFFFF_FFFF)) begin
                conflict_cnt <= conflict_cnt + 32'd1;
            end
            if (force_next && (force_cnt != 16'hFFFF)) begin
                force_cnt <= force_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the four byte-lane data-memory banks between two requesters.
  - Port A: the CPU execute stage, single-cycle, highest priority.
  - Port B: a loader/debug master, request/grant handshake.
- Sits between the CPU load/store path and the dmem banks.
- Routes the 1-cycle-latency synchronous read data back to whichever requester issued the read.
- Bounds B's starvation by stalling the CPU for one cycle after STARVE_LIMIT consecutive denials.

Parameters:
- ADDR_W, 32, width of the address on ports A, B and mem.
- STARVE_LIMIT, 8, consecutive denied B-request cycles before a forced B grant (legal range 1..255).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- a_req  in  1  CPU access this cycle (load or store)
- a_we  in  4  CPU byte-lane write enables (0000 = read)
- a_addr  in  ADDR_W  CPU dmem address
- a_wdata  in  32  CPU lane-aligned write data
- a_rdata  out  32  read data returned to CPU
- a_rvalid  out  1  a_rdata valid (cycle after an A read grant)
- cpu_stall  out  1  CPU must hold its ex-stage instruction and PC this cycle
- b_req  in  1  loader request, held until granted
- b_we  in  4  loader byte-lane write enables
- b_addr  in  ADDR_W  loader address
- b_wdata  in  32  loader write data
- b_gnt  out  1  loader request accepted this cycle
- b_rdata  out  32  read data returned to loader
- b_rvalid  out  1  b_rdata valid
- mem_we  out  4  bank byte write enables
- mem_addr  out  ADDR_W  bank address
- mem_wdata  out  32  bank write data
- mem_rdata  in  32  bank read data (registered inside banks, 1-cycle latency)

Behaviour:
- Reset: state=ARB_NORMAL, starve_cnt=0, rsel=NONE.
  - Outputs: cpu_stall=0, a_rvalid=0, b_rvalid=0, a_rdata=0, b_rdata=0.
  - b_gnt=0 and mem_we=0 while rst is high.
- Mid-operation reset discards any pending read return; no rvalid is issued after reset deasserts.
- Grant is combinational from the current state and requests, so A sees zero added latency.
- mem_* are muxed from the granted port; with no grant, mem_we=0, mem_addr=0, mem_wdata=0.
- ARB_NORMAL:
  - a_req=1: grant A.
  - a_req=0 and b_req=1: grant B, b_gnt=1.
  - a_req=1 and b_req=1 (denial): starve_cnt++.
  - Denial with starve_cnt==STARVE_LIMIT-1: next state ARB_FORCE_B, starve_cnt cleared.
  - Any B grant clears starve_cnt.
  - b_req=0 clears starve_cnt.
- ARB_FORCE_B (exactly one cycle):
  - cpu_stall=1 (registered; equals state==ARB_FORCE_B).
  - A is not granted regardless of a_req; the CPU re-presents its access next cycle.
  - B granted if b_req=1; if B dropped its request, the cycle is idle.
  - Next state is always ARB_NORMAL.
- cpu_stall is never asserted in ARB_NORMAL.
- Read routing (rsel register, set each cycle):
  - A if an A read (we==0) was granted.
  - B if a B read was granted.
  - NONE on writes or idle cycles.
- Next cycle after a read grant:
  - rsel=A: a_rvalid=1, a_rdata=mem_rdata.
  - rsel=B: b_rvalid=1, b_rdata=mem_rdata.
  - The non-selected rdata is 0.
- Simultaneous A write and B request: A wins; B's write is not performed and B holds its request.
- Back-to-back reads from alternating owners: each return is routed by the rsel captured at its own grant, with no bubble.
- B handshake: b_addr, b_we and b_wdata must be stable while b_req=1 and b_gnt=0. One beat per grant.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- Defined:
  - Adds output conflict_cnt (32 bit), reset 0.
  - Increments on every denial cycle; saturates at 32'hFFFF_FFFF.
  - Adds output force_cnt (16 bit), reset 0; increments on entry to ARB_FORCE_B; saturates.
- Undefined: neither port nor the counters exist; arbitration is identical.

Decomposition:
- Shared package/define header:
  - state encodings ARB_NORMAL / ARB_FORCE_B.
  - rsel encodings RSEL_NONE / RSEL_A / RSEL_B.
  - DMEM byte-enable constant WE_NONE=4'b0000.
- One sub-module: dmem_arb_starve_ctr.
  - Owns starve_cnt compare/clear.
  - Emits force_next.
- Grant mux and read routing stay in dmem_arbiter.

Test Plan:
- A-only traffic:
  - Stimulus: a_req=1, a_we=0, a_addr=0x40 with mem pre-loaded 0xDEADBEEF.
  - Response: next cycle a_rvalid=1, a_rdata=0xDEADBEEF; b_rvalid=0; cpu_stall=0 throughout.
- B-only write/read:
  - Stimulus: b_req write b_we=1111, b_addr=0x80, b_wdata=0x12345678, then a B read of 0x80.
  - Response: b_gnt=1 on each request cycle; read returns b_rvalid=1, b_rdata=0x12345678; a_rvalid stays 0.
- Starvation with STARVE_LIMIT=8:
  - Stimulus: a_req and b_req held high.
  - Response: 8 denial cycles; cycle 9 has cpu_stall=1, b_gnt=1, mem_addr=b_addr; cycle 10 A is granted; pattern repeats every 9 cycles.
- B drops request during force:
  - Stimulus: b_req deasserts on the cycle the arbiter enters ARB_FORCE_B.
  - Response: cpu_stall=1 for one cycle, mem_we=0, b_gnt=0; then normal operation.
- Alternating reads and reset:
  - Stimulus: A read 0x00 then B read 0x04 on consecutive cycles; then rst asserted while a B read return is pending.
  - Response: a_rvalid then b_rvalid on consecutive cycles with correct data; after the reset pulse, b_rvalid=0, cpu_stall=0, starve_cnt=0.
- DMEM_ARB_STATS_EN build, starvation scenario for 27 cycles:
  - Response: conflict_cnt=24, force_cnt=3.
